// File: rtl/sti_deser_if.sv
// Bundle of the serial-in, configuration, buffered-output and status signals of sti_deser.
// The master side drives the serial stream and consumer ready; the slave side is the deserializer.
interface sti_deser_if;
    logic        si_data;
    logic        si_valid;
    logic        si_end;
    logic [1:0]  cfg_length;
    logic        cfg_msb;
    logic [31:0] po_data;
    logic [5:0]  po_len;
    logic        po_err;
    logic        po_valid;
    logic        po_ready;
    logic        ovf;
    logic        rx_done;
    logic [7:0]  err_cnt;

    modport master (
        output si_data, si_valid, si_end, cfg_length, cfg_msb, po_ready,
        input  po_data, po_len, po_err, po_valid, ovf, rx_done, err_cnt
    );

    modport slave (
        input  si_data, si_valid, si_end, cfg_length, cfg_msb, po_ready,
        output po_data, po_len, po_err, po_valid, ovf, rx_done, err_cnt
    );
endinterface

// File: rtl/sti_deser.sv
// Serial-to-parallel frame deserializer with a 2-entry output FIFO and sticky status flags.
// Optional saturating error counter enabled by defining STI_DESER_ERRCNT_EN.
module sti_deser (
    input  logic         clk,
    input  logic         reset,
    sti_deser_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        w_start;
    logic        w_shift;
    logic        w_close;
    logic        w_rx_done;

    logic [31:0] r_acc;
    logic [5:0]  r_count;
    logic        r_oversize;
    logic [1:0]  r_len_cfg;
    logic        r_msb;

    logic [2:0]  w_len_units;
    logic [5:0]  w_exp_len;
    logic        w_frame_err;

    logic [31:0] r_mem_data [0:1];
    logic [5:0]  r_mem_len  [0:1];
    logic        r_mem_err  [0:1];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_fcnt;
    logic        r_ovf;

    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_push;
    logic        w_drop;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:  if (bus.si_valid) w_state_next = S_SHIFT;
            S_SHIFT: if (!bus.si_valid) w_state_next = bus.si_end ? S_DONE : S_IDLE;
            S_DONE:  w_state_next = S_DONE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_start   = 1'b0;
        w_shift   = 1'b0;
        w_close   = 1'b0;
        w_rx_done = 1'b0;
        unique case (r_state)
            S_IDLE:  w_start = bus.si_valid;
            S_SHIFT: begin
                w_shift = bus.si_valid;
                w_close = !bus.si_valid;
            end
            S_DONE:  w_rx_done = 1'b1;
            default: ;
        endcase
    end

    // ---------------- Shift datapath ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc      <= '0;
            r_count    <= '0;
            r_oversize <= 1'b0;
            r_len_cfg  <= '0;
            r_msb      <= 1'b0;
        end else if (w_start) begin
            r_acc      <= {31'd0, bus.si_data};
            r_count    <= 6'd1;
            r_oversize <= 1'b0;
            r_len_cfg  <= bus.cfg_length;
            r_msb      <= bus.cfg_msb;
        end else if (w_shift) begin
            // Past 32 bits the word is frozen; only the oversize flag records the excess.
            if (r_count == 6'd32) begin
                r_oversize <= 1'b1;
            end else begin
                if (r_msb) begin
                    r_acc <= {r_acc[30:0], bus.si_data};
                end else begin
                    r_acc[r_count[4:0]] <= bus.si_data;
                end
                r_count <= r_count + 6'd1;
            end
        end
    end

    assign w_len_units = {1'b0, r_len_cfg} + 3'd1;
    assign w_exp_len   = {w_len_units, 3'b000};
    assign w_frame_err = r_oversize | (r_count != w_exp_len);

    // ---------------- Output FIFO ----------------
    assign w_empty = (r_fcnt == 2'd0);
    assign w_full  = (r_fcnt == 2'd2);
    assign w_pop   = !w_empty && bus.po_ready;
    // When full, a simultaneous pop frees the slot the write pointer already targets.
    assign w_push  = w_close && (!w_full || w_pop);
    assign w_drop  = w_close && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= r_acc;
            r_mem_len[r_wr_ptr]  <= r_count;
            r_mem_err[r_wr_ptr]  <= w_frame_err;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_fcnt   <= 2'd0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            if (w_push && !w_pop)      r_fcnt <= r_fcnt + 2'd1;
            else if (w_pop && !w_push) r_fcnt <= r_fcnt - 2'd1;
            if (w_drop) r_ovf <= 1'b1;
        end
    end

    assign bus.po_valid = !w_empty;
    assign bus.po_data  = w_empty ? 32'd0 : r_mem_data[r_rd_ptr];
    assign bus.po_len   = w_empty ? 6'd0  : r_mem_len[r_rd_ptr];
    assign bus.po_err   = w_empty ? 1'b0  : r_mem_err[r_rd_ptr];
    assign bus.ovf      = r_ovf;
    assign bus.rx_done  = w_rx_done;

    // ---------------- Error counter ----------------
`ifdef STI_DESER_ERRCNT_EN
    logic [7:0] r_err_cnt;

    // Counts every closed erroneous frame, including ones dropped on overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_cnt <= 8'd0;
        end else if (w_close && w_frame_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign bus.err_cnt = r_err_cnt;
`else
    assign bus.err_cnt = 8'd0;
`endif

endmodule

// File: doc/sti_deser.md
STI_DESER -- requirements
Module: sti_deser

Interface
REQ-001 SHALL: reset reset, asynchronous, active-high; clock clk.
REQ-002 SHALL: clk  in  1  rising-edge clock for all state.
REQ-003 SHALL: reset  in  1  async active-high reset.
REQ-004 SHALL: si_data  in  1  serial bit from upstream transmitter (so_data).
REQ-005 SHALL: si_valid  in  1  bit-valid strobe; high for every cycle of a frame (so_valid).
REQ-006 SHALL: si_end  in  1  last-frame indicator (pi_end), sampled at frame close.
REQ-007 SHALL: cfg_length  in  2  expected frame length, 00=8, 01=16, 10=24, 11=32 bits.
REQ-008 SHALL: cfg_msb  in  1  1 = first bit is MSB; 0 = first bit is LSB.
REQ-009 SHALL: po_data  out  32  reassembled word, right-justified, upper bits zero.
REQ-010 SHALL: po_len  out  6  received bit count of the head entry, 1..32.
REQ-011 SHALL: po_err  out  1  head entry length differs from expected, or is oversize.
REQ-012 SHALL: po_valid  out  1  output buffer not empty.
REQ-013 SHALL: po_ready  in  1  consumer accepts head entry when po_valid and po_ready are both high.
REQ-014 SHALL: ovf  out  1  sticky; a frame was dropped because the buffer was full.
REQ-015 SHALL: rx_done  out  1  sticky; final frame (si_end) has been closed.
REQ-016 SHALL: err_cnt  out  8  saturating count of po_err frames (see Configuration).

Function
REQ-017 SHALL: FSM states are IDLE, SHIFT and DONE.
REQ-018 SHALL: IDLE -> SHIFT on the edge where si_valid=1; that bit is captured and cfg_length/cfg_msb are latched for the frame.
REQ-019 SHALL: in SHIFT, each edge with si_valid=1 captures one bit; count increments, saturates at 32; bits 33+ are discarded and set an oversize flag.
REQ-020 SHALL: MSB mode shifts left (acc = {acc[30:0], bit}); LSB mode writes the bit to acc[count]; result for N bits occupies [N-1:0].
REQ-021 SHALL: the first edge in SHIFT with si_valid=0 closes the frame: push {acc, count, err} into the buffer; err = oversize OR count != 8*(latched cfg_length+1).
REQ-022 SHALL: latency -- last bit captured at edge T, entry written at edge T+1, po_valid high after edge T+1.
REQ-023 SHALL: at close, next state is DONE if si_end=1, else IDLE; back-to-back frames need at least one idle cycle.
REQ-024 SHALL: DONE is terminal until reset; si_valid is ignored; rx_done=1 from the edge entering DONE.
REQ-025 SHALL: the buffer is a 2-entry FIFO with in-order output; po_data/po_len/po_err reflect the head entry, and are 0 when empty.
REQ-026 SHALL: push when full with no pop drops the new frame and sets ovf; push and pop on the same edge when full is legal with no drop.
REQ-027 SHALL: a pop when empty has no effect; pointers wrap modulo 2.

Reset
REQ-028 SHALL: reset clears all outputs to 0 and sets state to IDLE, empties the FIFO, clears acc/count/oversize, ovf, rx_done and err_cnt.
REQ-029 SHALL: reset mid-frame discards the partial frame; the next si_valid rise starts a fresh frame.

Configuration
REQ-030 SHALL: with STI_DESER_ERRCNT_EN defined, err_cnt increments on every closed frame with err=1 (including dropped ones) and saturates at 255.
REQ-031 SHALL: without STI_DESER_ERRCNT_EN, err_cnt is tied to 0 and the counter logic is absent; the port list is unchanged.

Verification
REQ-032 SHALL: cfg_length=0, cfg_msb=1, bits 1,0,1,1,0,0,1,0 -> po_data=0x000000B2, po_len=8, po_err=0, po_valid one cycle after si_valid falls.
REQ-033 SHALL: same bits with cfg_msb=0 -> po_data=0x0000004D, po_len=8, po_err=0.
REQ-034 SHALL: cfg_length=1, 12-bit frame -> po_len=12, po_err=1; err_cnt=1 with the macro, 0 without.
REQ-035 SHALL: po_ready=0, three 8-bit frames 0x11, 0x22, 0x33 -> 0x33 dropped, ovf=1; then po_ready=1 -> pops 0x11 then 0x22, po_valid=0.
REQ-036 SHALL: cfg_length=3, cfg_msb=1, 0xDEADBEEF with si_end=1 -> entry 0xDEADBEEF/32/0 and rx_done=1; a later 8-bit frame produces no entry.
REQ-037 SHALL: reset pulse after 5 bits of a frame -> all outputs 0; a following 16-bit frame 0xA5C3 decodes with po_err=0.
